// File: rtl/sky130io_gpio_seq_if.sv
// Pad-configuration request channel between the core register file and the GPIO sequencer.
interface sky130io_gpio_seq_if #(
  parameter int unsigned PadW = 2
) ();
  logic            cfg_valid;
  logic            cfg_ready;
  logic [PadW-1:0] cfg_pad;
  logic [2:0]      cfg_dm;
  logic            cfg_slow;
  logic            cfg_vtrip;
  logic            cfg_inp_dis;
  logic            cfg_err;

  modport master (
    output cfg_valid, cfg_pad, cfg_dm, cfg_slow, cfg_vtrip, cfg_inp_dis,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_pad, cfg_dm, cfg_slow, cfg_vtrip, cfg_inp_dis,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/sky130io_gpio_seq.sv
// Power-up sequencer and glitch-free per-pad configuration controller for a bank of
// sky130 gpiov2 pads; also freezes the bank for sleep.
module sky130io_gpio_seq #(
  parameter int unsigned NPADS    = 4,
  parameter int unsigned SETTLE   = 16,
  parameter int unsigned HOLD_CYC = 4
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 pwr_good,
  input  logic                 hold_req,
  sky130io_gpio_seq_if.slave   cfg,
  output logic                 ready,
  output logic                 enable_h,
  output logic                 enable_inp_h,
  output logic                 enable_vdda_h,
  output logic                 enable_vswitch_h,
  output logic [NPADS-1:0]     hld_h_n,
  output logic [3*NPADS-1:0]   dm,
  output logic [NPADS-1:0]     slow,
  output logic [NPADS-1:0]     vtrip_sel,
  output logic [NPADS-1:0]     inp_dis
);

  localparam int unsigned PadW   = (NPADS > 1) ? $clog2(NPADS) : 1;
  localparam int unsigned CntMax = (SETTLE > HOLD_CYC) ? SETTLE : HOLD_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] SettleLd = CntW'(SETTLE - 1);
  localparam logic [CntW-1:0] HoldLd   = CntW'(HOLD_CYC - 1);

  typedef enum logic [3:0] {
    StOff, StEnH, StEnInp, StRel, StRun, StCfgHold, StCfgRel, StSleep, StWake
  } state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    cnt_zero;
  logic                    stage_en, load_cfg, err_d, err_q;
  logic                    pad_ok;
  logic [PadW-1:0]         pad_q, sel_pad;
  logic [2:0]              stg_dm_q;
  logic                    stg_slow_q, stg_vtrip_q, stg_inp_dis_q;
  logic                    en_h_d, en_h_q, en_inp_d, en_inp_q, ready_d, ready_q;
  logic [NPADS-1:0]        hld_d, hld_q;
  logic [NPADS-1:0][2:0]   dm_q;
  logic [NPADS-1:0]        slow_q, vtrip_q, inp_dis_q;

  assign cnt_zero      = (cnt_q == '0);
  assign pad_ok        = (32'(cfg.cfg_pad) < NPADS);
  assign cfg.cfg_ready = (state_q == StRun) & pwr_good & ~hold_req;
  assign cfg.cfg_err   = err_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_zero ? cnt_q : cnt_q - 1'b1;
    stage_en = 1'b0;
    load_cfg = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      StOff: if (pwr_good) begin
        state_d = StEnH;
        cnt_d   = SettleLd;
      end
      StEnH: if (cnt_zero) begin
        state_d = StEnInp;
        cnt_d   = SettleLd;
      end
      StEnInp: if (cnt_zero) begin
        state_d = StRel;
        cnt_d   = HoldLd;
      end
      StRel: if (cnt_zero) state_d = StRun;
      StRun: begin
        if (hold_req) begin
          state_d = StSleep;
        end else if (cfg.cfg_valid) begin
          if (pad_ok) begin
            stage_en = 1'b1;
            state_d  = StCfgHold;
            cnt_d    = HoldLd;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StCfgHold: if (cnt_zero) begin
        load_cfg = 1'b1;
        state_d  = StCfgRel;
        cnt_d    = HoldLd;
      end
      StCfgRel: if (cnt_zero) state_d = StRun;
      StSleep: if (!hold_req) begin
        state_d = StWake;
        cnt_d   = HoldLd;
      end
      StWake: if (cnt_zero) state_d = StRun;
      default: state_d = StOff;
    endcase
    // Supply loss overrides everything and drops any staged update.
    if (!pwr_good) begin
      state_d  = StOff;
      stage_en = 1'b0;
      load_cfg = 1'b0;
      err_d    = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    sel_pad  = stage_en ? cfg.cfg_pad : pad_q;
    en_h_d   = (state_d != StOff);
    en_inp_d = (state_d != StOff) && (state_d != StEnH);
    ready_d  = (state_d == StRun);
    hld_d    = '0;
    case (state_d)
      StRun: hld_d = '1;
      StCfgHold, StCfgRel: begin
        for (int i = 0; i < int'(NPADS); i++) begin
          hld_d[i] = (sel_pad != PadW'(i));
        end
      end
      default: hld_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q       <= StOff;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      en_h_q        <= 1'b0;
      en_inp_q      <= 1'b0;
      ready_q       <= 1'b0;
      hld_q         <= '0;
      pad_q         <= '0;
      stg_dm_q      <= 3'b001;
      stg_slow_q    <= 1'b0;
      stg_vtrip_q   <= 1'b0;
      stg_inp_dis_q <= 1'b1;
      dm_q          <= {NPADS{3'b001}};
      slow_q        <= '0;
      vtrip_q       <= '0;
      inp_dis_q     <= '1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      en_h_q   <= en_h_d;
      en_inp_q <= en_inp_d;
      ready_q  <= ready_d;
      hld_q    <= hld_d;
      if (stage_en) begin
        pad_q         <= cfg.cfg_pad;
        stg_dm_q      <= cfg.cfg_dm;
        stg_slow_q    <= cfg.cfg_slow;
        stg_vtrip_q   <= cfg.cfg_vtrip;
        stg_inp_dis_q <= cfg.cfg_inp_dis;
      end
      if (load_cfg) begin
        for (int i = 0; i < int'(NPADS); i++) begin
          if (pad_q == PadW'(i)) begin
            dm_q[i]      <= stg_dm_q;
            slow_q[i]    <= stg_slow_q;
            vtrip_q[i]   <= stg_vtrip_q;
            inp_dis_q[i] <= stg_inp_dis_q;
          end
        end
      end
    end
  end

  assign ready            = ready_q;
  assign enable_h         = en_h_q;
  assign enable_inp_h     = en_inp_q;
  assign enable_vdda_h    = en_inp_q;
  assign enable_vswitch_h = en_inp_q;
  assign hld_h_n          = hld_q;
  assign dm               = dm_q;
  assign slow             = slow_q;
  assign vtrip_sel        = vtrip_q;
  assign inp_dis          = inp_dis_q;

endmodule

// File: tb/tb_sky130io_gpio_seq.sv
// Scoreboard bench: expectations are queued with the cycle they are due and checked on negedge.
module tb_sky130io_gpio_seq;

  // Instance A uses the default sizing, B a 5-pad bank so an out-of-range index is encodable.
  localparam int ObAEnH = 0, ObAEnInp = 1, ObAEnVdda = 2, ObAEnVsw = 3, ObAHld = 4;
  localparam int ObARdy = 5, ObADm = 6, ObASlow = 7, ObAVtrip = 8, ObAInpDis = 9;
  localparam int ObACfgRdy = 10, ObACfgErr = 11, ObBHld = 12, ObBRdy = 13, ObBDm = 14;
  localparam int ObBCfgRdy = 15, ObBCfgErr = 16, ObBSlow = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nreset, pwr_good, hold_a, hold_b;
  logic ready_a, en_h_a, en_inp_a, en_vdda_a, en_vsw_a;
  logic [3:0] hld_a, slow_a, vtrip_a, inp_dis_a;
  logic [11:0] dm_a;
  logic ready_b, en_h_b, en_inp_b, en_vdda_b, en_vsw_b;
  logic [4:0] hld_b, slow_b, vtrip_b, inp_dis_b;
  logic [14:0] dm_b;

  sky130io_gpio_seq_if #(.PadW(2)) cfg_a_if ();
  sky130io_gpio_seq_if #(.PadW(3)) cfg_b_if ();

  sky130io_gpio_seq #(.NPADS(4), .SETTLE(16), .HOLD_CYC(4)) u_dut_a (
    .clk(clk), .nreset(nreset), .pwr_good(pwr_good), .hold_req(hold_a), .cfg(cfg_a_if.slave),
    .ready(ready_a), .enable_h(en_h_a), .enable_inp_h(en_inp_a), .enable_vdda_h(en_vdda_a),
    .enable_vswitch_h(en_vsw_a), .hld_h_n(hld_a), .dm(dm_a), .slow(slow_a),
    .vtrip_sel(vtrip_a), .inp_dis(inp_dis_a)
  );

  sky130io_gpio_seq #(.NPADS(5), .SETTLE(2), .HOLD_CYC(1)) u_dut_b (
    .clk(clk), .nreset(nreset), .pwr_good(pwr_good), .hold_req(hold_b), .cfg(cfg_b_if.slave),
    .ready(ready_b), .enable_h(en_h_b), .enable_inp_h(en_inp_b), .enable_vdda_h(en_vdda_b),
    .enable_vswitch_h(en_vsw_b), .hld_h_n(hld_b), .dm(dm_b), .slow(slow_b),
    .vtrip_sel(vtrip_b), .inp_dis(inp_dis_b)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  int unsigned sb_cyc[$];
  int          sb_sel[$];
  logic [31:0] sb_exp[$];
  string       sb_tag[$];

  // Bench model of the configuration outputs.
  logic [11:0] m_dm_a;
  logic [3:0]  m_slow_a, m_vtrip_a, m_inp_a;
  logic [14:0] m_dm_b;
  logic [4:0]  m_slow_b;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      ObAEnH:    return 32'(en_h_a);
      ObAEnInp:  return 32'(en_inp_a);
      ObAEnVdda: return 32'(en_vdda_a);
      ObAEnVsw:  return 32'(en_vsw_a);
      ObAHld:    return 32'(hld_a);
      ObARdy:    return 32'(ready_a);
      ObADm:     return 32'(dm_a);
      ObASlow:   return 32'(slow_a);
      ObAVtrip:  return 32'(vtrip_a);
      ObAInpDis: return 32'(inp_dis_a);
      ObACfgRdy: return 32'(cfg_a_if.cfg_ready);
      ObACfgErr: return 32'(cfg_a_if.cfg_err);
      ObBHld:    return 32'(hld_b);
      ObBRdy:    return 32'(ready_b);
      ObBDm:     return 32'(dm_b);
      ObBCfgRdy: return 32'(cfg_b_if.cfg_ready);
      ObBCfgErr: return 32'(cfg_b_if.cfg_err);
      ObBSlow:   return 32'(slow_b);
      default:   return 32'hdead_beef;
    endcase
  endfunction

  task automatic push(input int sel, input logic [31:0] exp, input int unsigned at,
                      input string tag);
    sb_cyc.push_back(at);
    sb_sel.push_back(sel);
    sb_exp.push_back(exp);
    sb_tag.push_back(tag);
  endtask

  task automatic push_rng(input int sel, input logic [31:0] exp, input int unsigned from,
                          input int unsigned to, input string tag);
    for (int unsigned c = from; c <= to; c++) push(sel, exp, c, tag);
  endtask

  always @(negedge clk) begin
    for (int i = sb_cyc.size() - 1; i >= 0; i--) begin
      if (sb_cyc[i] == cyc) begin
        check_eq(sb_tag[i], obs(sb_sel[i]), sb_exp[i]);
        sb_cyc.delete(i);
        sb_sel.delete(i);
        sb_exp.delete(i);
        sb_tag.delete(i);
      end
    end
  end

  task automatic wait_cyc(input int unsigned c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_a(input logic v, input logic [1:0] p, input logic [2:0] d,
                         input logic s, input logic vt, input logic id);
    cfg_a_if.cfg_valid   = v;
    cfg_a_if.cfg_pad     = p;
    cfg_a_if.cfg_dm      = d;
    cfg_a_if.cfg_slow    = s;
    cfg_a_if.cfg_vtrip   = vt;
    cfg_a_if.cfg_inp_dis = id;
  endtask

  task automatic drive_b(input logic v, input logic [2:0] p, input logic [2:0] d,
                         input logic s);
    cfg_b_if.cfg_valid   = v;
    cfg_b_if.cfg_pad     = p;
    cfg_b_if.cfg_dm      = d;
    cfg_b_if.cfg_slow    = s;
    cfg_b_if.cfg_vtrip   = 1'b0;
    cfg_b_if.cfg_inp_dis = 1'b1;
  endtask

  initial begin
    nreset = 1'b0; pwr_good = 1'b0; hold_a = 1'b0; hold_b = 1'b0;
    drive_a(1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0);
    drive_b(1'b0, 3'd0, 3'b000, 1'b0);
    m_dm_a = 12'h249; m_slow_a = 4'h0; m_vtrip_a = 4'h0; m_inp_a = 4'hF;
    m_dm_b = 15'h1249; m_slow_b = 5'h0;

    // Reset values
    wait_cyc(2);
    push(ObAEnH, 0, 2, "rst_en_h");     push(ObAEnInp, 0, 2, "rst_en_inp");
    push(ObAHld, 0, 2, "rst_hld");      push(ObARdy, 0, 2, "rst_ready");
    push(ObADm, m_dm_a, 2, "rst_dm");   push(ObAInpDis, m_inp_a, 2, "rst_inp_dis");
    push(ObASlow, 0, 2, "rst_slow");    push(ObAVtrip, 0, 2, "rst_vtrip");
    push(ObACfgRdy, 0, 2, "rst_cfg_ready"); push(ObACfgErr, 0, 2, "rst_cfg_err");
    push(ObBDm, m_dm_b, 2, "rst_dm_b");
    wait_cyc(5);
    nreset = 1'b1;

    // Power-up: pwr_good sampled at edge 11
    wait_cyc(10);
    pwr_good = 1'b1;
    push(ObAEnH, 0, 10, "pu_en_h_pre");   push(ObAEnH, 1, 11, "pu_en_h");
    push(ObAEnInp, 0, 26, "pu_inp_pre");  push(ObAEnInp, 1, 27, "pu_inp");
    push(ObAEnVdda, 1, 27, "pu_vdda");    push(ObAEnVsw, 1, 27, "pu_vswitch");
    push(ObAHld, 0, 46, "pu_hld_pre");    push(ObAHld, 4'hF, 47, "pu_hld");
    push(ObARdy, 0, 46, "pu_ready_pre");  push(ObARdy, 1, 47, "pu_ready");
    push(ObACfgRdy, 1, 47, "pu_cfg_ready");
    push(ObBRdy, 0, 15, "pu_b_ready_pre"); push(ObBRdy, 1, 16, "pu_b_ready");

    // Out-of-range pad on B, accepted at edge 21
    wait_cyc(20);
    drive_b(1'b1, 3'd5, 3'b111, 1'b1);
    push(ObBCfgRdy, 1, 20, "err_b_cfg_ready");
    push(ObBCfgErr, 0, 20, "err_b_pre"); push(ObBCfgErr, 1, 21, "err_b_pulse");
    push(ObBCfgErr, 0, 22, "err_b_post");
    push(ObBCfgRdy, 1, 21, "err_b_ready_kept"); push(ObBCfgRdy, 1, 22, "err_b_ready_kept");
    push_rng(ObBHld, 5'h1F, 21, 22, "err_b_hld");
    push(ObBDm, m_dm_b, 22, "err_b_dm");
    wait_cyc(21);
    drive_b(1'b0, 3'd0, 3'b000, 1'b0);

    // Valid update on B (HOLD_CYC=1), accepted at edge 25
    wait_cyc(24);
    drive_b(1'b1, 3'd4, 3'b010, 1'b1);
    push(ObBCfgRdy, 0, 25, "cfg_b_busy");
    push_rng(ObBHld, 5'h0F, 25, 26, "cfg_b_hld");
    push(ObBHld, 5'h1F, 27, "cfg_b_hld_rel");
    push(ObBDm, m_dm_b, 25, "cfg_b_dm_old");
    m_dm_b[14:12] = 3'b010; m_slow_b[4] = 1'b1;
    push(ObBDm, m_dm_b, 26, "cfg_b_dm_new"); push(ObBSlow, m_slow_b, 26, "cfg_b_slow");
    wait_cyc(25);
    drive_b(1'b0, 3'd0, 3'b000, 1'b0);

    // Pad 2 update on A, accepted at edge 51
    wait_cyc(50);
    drive_a(1'b1, 2'd2, 3'b110, 1'b1, 1'b1, 1'b0);
    push(ObACfgRdy, 1, 50, "cfg2_ready_pre");
    push_rng(ObAHld, 4'b1011, 51, 58, "cfg2_hld");
    push(ObAHld, 4'hF, 59, "cfg2_hld_rel");
    push(ObACfgRdy, 0, 51, "cfg2_busy"); push(ObACfgRdy, 0, 58, "cfg2_busy_end");
    push(ObACfgRdy, 1, 59, "cfg2_ready_post"); push(ObACfgErr, 0, 51, "cfg2_no_err");
    push(ObADm, m_dm_a, 54, "cfg2_dm_old"); push(ObASlow, m_slow_a, 54, "cfg2_slow_old");
    m_dm_a[8:6] = 3'b110; m_slow_a[2] = 1'b1; m_vtrip_a[2] = 1'b1; m_inp_a[2] = 1'b0;
    push(ObADm, m_dm_a, 55, "cfg2_dm_new");   push(ObASlow, m_slow_a, 55, "cfg2_slow_new");
    push(ObAVtrip, m_vtrip_a, 55, "cfg2_vtrip"); push(ObAInpDis, m_inp_a, 55, "cfg2_inp_dis");
    wait_cyc(51);
    drive_a(1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0);

    // hold_req and cfg_valid together: sleep wins, nothing staged
    wait_cyc(62);
    hold_a = 1'b1;
    drive_a(1'b1, 2'd1, 3'b111, 1'b1, 1'b1, 1'b0);
    push(ObACfgRdy, 0, 62, "slp_cfg_ready");
    push(ObAHld, 0, 63, "slp_hld"); push(ObARdy, 0, 63, "slp_ready");
    push(ObADm, m_dm_a, 66, "slp_dm");
    wait_cyc(70);
    hold_a = 1'b0;
    drive_a(1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0);
    push(ObAHld, 0, 74, "wake_hld_pre"); push(ObAHld, 4'hF, 75, "wake_hld");
    push(ObARdy, 1, 75, "wake_ready"); push(ObAHld, 4'hF, 77, "wake_no_stage");
    push(ObADm, m_dm_a, 77, "wake_dm");

    // Supply loss mid CFG_HOLD (accepted edge 81, pwr_good low sampled edge 83)
    wait_cyc(80);
    drive_a(1'b1, 2'd0, 3'b100, 1'b0, 1'b0, 1'b1);
    push(ObAHld, 4'b1110, 82, "pd_hld_in_cfg");
    wait_cyc(81);
    drive_a(1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0);
    wait_cyc(82);
    pwr_good = 1'b0;
    push(ObAEnH, 0, 83, "pd_en_h");    push(ObAEnInp, 0, 83, "pd_en_inp");
    push(ObAEnVdda, 0, 83, "pd_vdda"); push(ObAEnVsw, 0, 83, "pd_vswitch");
    push(ObAHld, 0, 83, "pd_hld");     push(ObARdy, 0, 83, "pd_ready");
    push(ObADm, m_dm_a, 83, "pd_dm_kept"); push(ObADm, m_dm_a, 90, "pd_dm_discard");

    // Re-power, sampled at edge 96
    wait_cyc(95);
    pwr_good = 1'b1;
    push(ObAEnH, 0, 95, "rp_en_h_pre");  push(ObAEnH, 1, 96, "rp_en_h");
    push(ObAEnInp, 0, 111, "rp_inp_pre"); push(ObAEnInp, 1, 112, "rp_inp");
    push(ObAHld, 0, 131, "rp_hld_pre");  push(ObAHld, 4'hF, 132, "rp_hld");
    push(ObARdy, 1, 132, "rp_ready");

    // Pad 0 update then synchronous reset
    wait_cyc(140);
    drive_a(1'b1, 2'd0, 3'b100, 1'b0, 1'b0, 1'b1);
    push_rng(ObAHld, 4'b1110, 141, 148, "cfg0_hld");
    push(ObAHld, 4'hF, 149, "cfg0_hld_rel");
    push(ObADm, m_dm_a, 144, "cfg0_dm_old");
    m_dm_a[2:0] = 3'b100;
    push(ObADm, m_dm_a, 145, "cfg0_dm_new"); push(ObASlow, m_slow_a, 145, "cfg0_slow");
    wait_cyc(141);
    drive_a(1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0);
    wait_cyc(152);
    nreset = 1'b0;
    m_dm_a = 12'h249; m_slow_a = 4'h0; m_vtrip_a = 4'h0; m_inp_a = 4'hF;
    push(ObADm, m_dm_a, 153, "nrst_dm");     push(ObAInpDis, m_inp_a, 153, "nrst_inp_dis");
    push(ObASlow, m_slow_a, 153, "nrst_slow"); push(ObAVtrip, m_vtrip_a, 153, "nrst_vtrip");
    push(ObAEnH, 0, 153, "nrst_en_h");     push(ObAEnInp, 0, 153, "nrst_en_inp");
    push(ObARdy, 0, 153, "nrst_ready");    push(ObAHld, 0, 153, "nrst_hld");
    wait_cyc(155);
    nreset = 1'b1;

    wait_cyc(160);
    check_eq("sb_drain", 32'(sb_cyc.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
